// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt controller: FSM state encoding,
// default sizing constants and the lowest-index priority encoder.
package intr_pkg;

  localparam int N_SRC_DEF       = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int ID_W_MAX        = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // Index of the lowest set bit; zero when nothing is set (callers gate on |vec).
  function automatic logic [ID_W_MAX-1:0] lowest_idx(input logic [31:0] vec);
    logic [ID_W_MAX-1:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = i[ID_W_MAX-1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/intr_sync.sv
// Single-bit multi-flop synchronizer for one raw interrupt line.
// Asynchronous active-low reset clears every stage so release never fakes a 1.
module intr_sync
  import intr_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_p0;

  // Shift the raw line through the synchronizer chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_p0 <= '0;
    else      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], d};
  end

  assign q = sync_p0[SYNC_STAGES-1];

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: synchronizes N_SRC raw lines, keeps a pending bit per
// line, and runs an IDLE -> REQ -> SERVICE handshake with the pipeline
// (ack_i accepts the request, eoi_i/eoi_id_i retires it).
// Build option: define INTR_EDGE_EN to add edge_mode_i and per-line
// rising-edge capture; without it every line is level-sensitive.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int N_SRC       = N_SRC_DEF,
  parameter int ID_W        = 3,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_i,
  input  logic [N_SRC-1:0] mask_i,
`ifdef INTR_EDGE_EN
  input  logic [N_SRC-1:0] edge_mode_i,
`endif
  output logic             irq_o,
  output logic [ID_W-1:0]  irq_id_o,
  input  logic             ack_i,
  input  logic             eoi_i,
  input  logic [ID_W-1:0]  eoi_id_i,
  output logic [N_SRC-1:0] pending_o,
  output logic             busy_o
);

  logic [N_SRC-1:0] s;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] pending_nxt;
  logic [N_SRC-1:0] req_vec;
  logic [ID_W-1:0]  irq_id;
  logic             eoi_take;
  state_t           state;
  state_t           state_nxt;

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_sync
    intr_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk(clk),
      .rst(rst),
      .d  (src_i[gi]),
      .q  (s[gi])
    );
  end

  // Masking applies only to arbitration; pending_o shows the raw pending view.
  assign req_vec  = pending & mask_i;
  assign eoi_take = (state == SERVICE) && eoi_i && (eoi_id_i == irq_id);

`ifdef INTR_EDGE_EN
  logic [N_SRC-1:0] s_d;
  logic [N_SRC-1:0] rise;
  logic             ack_take;

  // Delay the synchronized lines by one cycle for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) s_d <= '0;
    else      s_d <= s;
  end

  assign rise     = s & ~s_d;
  assign ack_take = (state == REQ) && ack_i;

  // Edge lines hold until their own ack (a new edge in that cycle wins);
  // level lines simply follow the synchronized input.
  always_comb begin
    pending_nxt = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (edge_mode_i[i])
        pending_nxt[i] = rise[i] |
                         (pending[i] & ~(ack_take && (irq_id == ID_W'(i))));
      else
        pending_nxt[i] = s[i];
    end
  end
`else
  assign pending_nxt = s;
`endif

  // Pending bit register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending <= '0;
    else      pending <= pending_nxt;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // FSM next-state: arbitrate in IDLE, wait for ack in REQ, wait for matching EOI.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req_vec) state_nxt = REQ;
      REQ:     if (ack_i)    state_nxt = SERVICE;
      SERVICE: if (eoi_take) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Latch the winning line when leaving IDLE; held through REQ and SERVICE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      irq_id <= '0;
    else if (state == IDLE && |req_vec)
      irq_id <= ID_W'(lowest_idx(32'(req_vec)));
  end

  // FSM outputs decoded from the registered state.
  always_comb begin
    irq_o  = (state == REQ);
    busy_o = (state != IDLE);
  end

  assign irq_id_o  = irq_id;
  assign pending_o = pending;

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 Parameter N_SRC, default 8: number of interrupt source lines (2..32).
REQ-002 Parameter ID_W, default 3: width of source ID, SHALL equal clog2(N_SRC).
REQ-003 Parameter SYNC_STAGES, default 2: synchronizer flops per source line (>=2).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 src_i  input  N_SRC  raw asynchronous interrupt lines, active-high.
REQ-007 mask_i  input  N_SRC  per-line enable, 1 = line may request.
REQ-008 edge_mode_i  input  N_SRC  per-line mode, 1 = rising-edge, 0 = level (present only with INTR_EDGE_EN).
REQ-009 irq_o  output  1  interrupt request to pipeline.
REQ-010 irq_id_o  output  ID_W  ID of the requesting/in-service line.
REQ-011 ack_i  input  1  pipeline accepts request (sampled only while irq_o=1).
REQ-012 eoi_i  input  1  end-of-interrupt strobe.
REQ-013 eoi_id_i  input  ID_W  ID being retired with eoi_i.
REQ-014 pending_o  output  N_SRC  registered pending bits (unmasked view).
REQ-015 busy_o  output  1  1 while FSM is not IDLE.

Function
REQ-016 Each src_i bit SHALL pass through SYNC_STAGES flops giving s; s_d is s delayed one cycle.
REQ-017 Level line: pending bit SHALL be loaded with s every cycle.
REQ-018 Edge line: pending bit SHALL set on s & ~s_d, clear on ack of that ID; set wins over clear in the same cycle.
REQ-019 FSM states IDLE, REQ, SERVICE; reset state IDLE.
REQ-020 IDLE: if any (pending & mask), latch lowest-index such line into irq_id_o, go REQ with irq_o=1 registered.
REQ-021 REQ: irq_o and irq_id_o SHALL stay stable until ack_i=1; mask changes SHALL NOT withdraw the request.
REQ-022 REQ + ack_i: irq_o=0 next cycle, go SERVICE; irq_id_o held.
REQ-023 SERVICE: no new request issued; eoi_i with eoi_id_i == irq_id_o returns to IDLE; mismatching or out-of-state eoi_i ignored.
REQ-024 ack_i outside REQ SHALL be ignored.
REQ-025 Latency: src_i change to irq_o=1 SHALL be SYNC_STAGES+2 cycles from an idle FSM.
REQ-026 Back-to-back: IDLE re-arbitrates the cycle after EOI; earliest next irq_o is 1 cycle after return to IDLE.
REQ-027 Edges arriving while a line is pending or in service SHALL merge into one pending bit (no counting).

Reset
REQ-028 rst=0 SHALL asynchronously clear synchronizers, s_d, pending, FSM (IDLE), irq_o=0, irq_id_o=0, busy_o=0, pending_o=0.
REQ-029 Reset mid-REQ or mid-SERVICE SHALL drop irq_o immediately; no EOI required afterward.
REQ-030 Release of rst SHALL NOT create spurious edges (s_d reset to 0, s reset to 0, first edge needs a real 0->1).

Configuration
REQ-031 Macro INTR_EDGE_EN defined: edge_mode_i present, per-line edge/level per REQ-017/018.
REQ-032 INTR_EDGE_EN undefined: edge_mode_i absent, s_d and edge logic removed, every line level-sensitive.

Structure
REQ-033 Shared package intr_pkg SHALL hold FSM state enum (IDLE/REQ/SERVICE) and default N_SRC/SYNC_STAGES constants.
REQ-034 One sub-module intr_sync (SYNC_STAGES-deep, 1-bit, async active-low reset) instantiated N_SRC times.
REQ-035 Priority encoder stays inline (function in intr_pkg).

Verification
REQ-036 Level: N_SRC=8, mask=FF, src_i[5]=1 -> irq_o=1, irq_id_o=5 at cycle 4; ack -> irq_o=0; eoi_id=5 with src still high -> re-request id 5.
REQ-037 Priority: src_i[6] and src_i[2] rise together -> id 2 first; after ack+eoi(2) -> id 6.
REQ-038 Edge (INTR_EDGE_EN, edge_mode=FF): 3 pulses on src_i[1] before ack -> exactly one request; pulse during ack cycle -> second request after eoi.
REQ-039 Mask/EOI: mask[3]=0 with src_i[3]=1 -> no irq_o; set mask[3] -> request; eoi_id=4 in SERVICE for id 3 -> stays SERVICE.
REQ-040 Reset: assert rst=0 during SERVICE -> irq_o=0, busy_o=0 same cycle; release with src_i=0 -> no request.
REQ-041 Scaling: N_SRC=32, ID_W=5, SYNC_STAGES=3, src_i[31] -> irq_id_o=31, latency 5 cycles.
